// File: rtl/charge_arb_pkg.sv
// Shared types and constants for the fare-charge display arbiter.
package charge_arb_pkg;

    // Arbiter FSM encoding; the explicit 2-bit base keeps it legacy-friendly.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default width of one charge code.
    localparam int DEFAULT_CHARGE_W = 4;

    // Charge codes produced by the fare compute units. Codes above CHG_TEN
    // are never generated by a healthy bay but are displayed unchanged.
    localparam logic [3:0] CHG_NONE  = 4'd0;
    localparam logic [3:0] CHG_ONE   = 4'd1;
    localparam logic [3:0] CHG_TWO   = 4'd2;
    localparam logic [3:0] CHG_THREE = 4'd3;
    localparam logic [3:0] CHG_FOUR  = 4'd4;
    localparam logic [3:0] CHG_FIVE  = 4'd5;
    localparam logic [3:0] CHG_SIX   = 4'd6;
    localparam logic [3:0] CHG_SEVEN = 4'd7;
    localparam logic [3:0] CHG_EIGHT = 4'd8;
    localparam logic [3:0] CHG_NINE  = 4'd9;
    localparam logic [3:0] CHG_TEN   = 4'd10;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request bit scanning
// upward from ptr, wrapping modulo NUM_BAYS (any value, not only powers of 2).
module rr_pick
    import charge_arb_pkg::*;
#(
    parameter int NUM_BAYS = 4,
    parameter int IDX_W    = $clog2(NUM_BAYS)
) (
    input  logic [NUM_BAYS-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic                valid,
    output logic [IDX_W-1:0]    idx,
    output logic [NUM_BAYS-1:0] onehot
);

    // Scan every bay once in priority order starting at ptr; first hit wins.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        // NOTE: every output gets a default before the loop so no path can
        // leave a value unassigned and infer a latch.
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int k = 0; k < NUM_BAYS; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_BAYS) begin
                cand = cand - NUM_BAYS;
            end
            cand_idx = IDX_W'(cand);
            if (!valid && req[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
        if (valid) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/charge_bay_arbiter.sv
// Round-robin arbiter granting one charging bay at a time the shared
// seven-segment display path. The granted bay's charge code is latched and
// held until the user refreshes or the bay withdraws its request.
// Optional feature: define CHARGE_ARB_TIMEOUT_EN to end the hold after
// HOLD_CYCLES clocks as a normal completion.
module charge_bay_arbiter
    import charge_arb_pkg::*;
#(
    parameter int NUM_BAYS    = 4,
    parameter int CHARGE_W    = DEFAULT_CHARGE_W,
    parameter int HOLD_CYCLES = 50000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_BAYS-1:0]          req,
    input  logic [NUM_BAYS*CHARGE_W-1:0] charge_in,
    input  logic                         refresh,
    output logic [NUM_BAYS-1:0]          grant,
    output logic [CHARGE_W-1:0]          disp_charge,
    output logic [$clog2(NUM_BAYS)-1:0]  disp_bay,
    output logic                         disp_valid,
    output logic [NUM_BAYS-1:0]          done,
    output logic                         busy
);

    localparam int IDX_W  = $clog2(NUM_BAYS);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t              state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [HOLD_W-1:0]   hold_cnt;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic [NUM_BAYS-1:0] pick_onehot;

    logic                hold_at_max;
    logic                timeout_hit;
    logic                normal_done;
    logic                abort_done;
    logic [IDX_W-1:0]    next_ptr;
    logic [NUM_BAYS-1:0] served_onehot;

    rr_pick #(
        .NUM_BAYS (NUM_BAYS),
        .IDX_W    (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // Decode the ways out of SHOW and the pointer for the next arbitration.
    always_comb begin
        hold_at_max = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
`ifdef CHARGE_ARB_TIMEOUT_EN
        timeout_hit = hold_at_max;
`else
        timeout_hit = 1'b0;
`endif
        // Refresh or timeout wins over a simultaneous withdrawal.
        normal_done   = refresh | timeout_hit;
        abort_done    = ~req[disp_bay];
        next_ptr      = (disp_bay == IDX_W'(NUM_BAYS - 1)) ? '0 : disp_bay + 1'b1;
        served_onehot = '0;
        served_onehot[disp_bay] = 1'b1;
    end

    assign busy = (state != IDLE);

    // Arbiter FSM with registered display outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            disp_charge <= '0;
            disp_bay    <= '0;
            disp_valid  <= 1'b0;
            done        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the pre-edge values, independent of statement order.
            case (state)
                IDLE: begin
                    done <= '0;
                    if (pick_valid) begin
                        grant       <= pick_onehot;
                        disp_bay    <= pick_idx;
                        disp_charge <= charge_in[pick_idx*CHARGE_W +: CHARGE_W];
                        disp_valid  <= 1'b1;
                        hold_cnt    <= '0;
                        state       <= SHOW;
                    end
                end

                SHOW: begin
                    if (!hold_at_max) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    if (normal_done || abort_done) begin
                        grant      <= '0;
                        disp_valid <= 1'b0;
                        hold_cnt   <= '0;
                        rr_ptr     <= next_ptr;
                        done       <= normal_done ? served_onehot : '0;
                        state      <= DONE;
                    end
                end

                DONE: begin
                    // Return the display fields to their idle values.
                    done        <= '0;
                    disp_bay    <= '0;
                    disp_charge <= '0;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_charge_bay_arbiter.sv
// Directed self-checking bench for charge_bay_arbiter (NUM_BAYS=4,
// HOLD_CYCLES=8). Build with +define+CHARGE_ARB_TIMEOUT_EN to cover the
// hold timeout; without it the bench checks that the hold never expires.
`timescale 1ns/1ps
module tb_charge_bay_arbiter;
    import charge_arb_pkg::*;

    localparam int NB = 4;
    localparam int CW = 4;

    logic             clk;
    logic             reset;
    logic [NB-1:0]    req;
    logic [NB*CW-1:0] charge_in;
    logic             refresh;
    logic [NB-1:0]    grant;
    logic [CW-1:0]    disp_charge;
    logic [1:0]       disp_bay;
    logic             disp_valid;
    logic [NB-1:0]    done;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    charge_bay_arbiter #(
        .NUM_BAYS    (NB),
        .CHARGE_W    (CW),
        .HOLD_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .charge_in   (charge_in),
        .refresh     (refresh),
        .grant       (grant),
        .disp_charge (disp_charge),
        .disp_bay    (disp_bay),
        .disp_valid  (disp_valid),
        .done        (done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; return on the following falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_charge(input int bay, input logic [CW-1:0] v);
        charge_in[bay*CW +: CW] = v;
    endtask

    // Outputs expected while the arbiter sits idle.
    task automatic check_idle(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_valid"}, disp_valid, 0);
        check({tag, "_charge"}, disp_charge, 0);
        check({tag, "_bay"}, disp_bay, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Grant followed by a refresh; bay drops req while done is seen.
    task automatic serve(input string tag, input int bay);
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        check({tag, "_done"}, done, 32'(1 << bay));
        req[bay] = 1'b0;
        step();
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    int             cnt;
    logic [CW-1:0]  loop_chg [NB];

    initial begin
        reset     = 1'b1;
        req       = '0;
        charge_in = '0;
        refresh   = 1'b0;
        loop_chg  = '{CHG_NONE, 4'd11, 4'd15, CHG_TEN};

        // Reset values, then idle with no requests.
        step();
        check_idle("rst");
        reset = 1'b0;
        step();
        step();
        check_idle("noreq");

        // Single request from bay 2 with charge 5: one-cycle grant latency.
        req = 4'b0100;
        set_charge(2, CHG_FIVE);
        step();
        check("s1_grant", grant, 32'h4);
        check("s1_bay", disp_bay, 2);
        check("s1_charge", disp_charge, CHG_FIVE);
        check("s1_valid", disp_valid, 1);
        check("s1_busy", busy, 1);
        step();
        check("s1_hold", grant, 32'h4);

        // Refresh: one-cycle DONE with a pulse to bay 2.
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        req     = '0;
        check("s2_done", done, 32'h4);
        check("s2_grant", grant, 0);
        check("s2_valid", disp_valid, 0);
        check("s2_busy", busy, 1);
        step();
        check_idle("s2_idle");

        // rr_ptr is now 3: bays 0 and 3 requesting must pick bay 3.
        req = 4'b1001;
        step();
        check("ptr3_grant", grant, 32'h8);
        req[0] = 1'b0;
        serve("ptr3", 3);

        // All four request; grants go 0,1,2,3 with charges incl. 0, 11, 15.
        for (int b = 0; b < NB; b++) set_charge(b, loop_chg[b]);
        req = 4'b1111;
        for (int b = 0; b < NB; b++) begin
            step();
            check($sformatf("rr%0d_grant", b), grant, 32'(1 << b));
            check($sformatf("rr%0d_charge", b), disp_charge, loop_chg[b]);
            serve($sformatf("rr%0d", b), b);
        end

        // Bay 3 completion wrapped rr_ptr to 0: bays 0 and 3 pick bay 0.
        req = 4'b1001;
        step();
        check("wrap_grant", grant, 32'h1);
        req[3] = 1'b0;
        serve("wrap", 0);

        // Bay 1 (charge 7) withdraws while its code changes to 9.
        set_charge(1, CHG_SEVEN);
        req = 4'b0010;
        step();
        check("ab_grant", grant, 32'h2);
        check("ab_charge0", disp_charge, CHG_SEVEN);
        set_charge(1, CHG_NINE);
        step();
        check("ab_charge1", disp_charge, CHG_SEVEN);
        req = '0;
        step();
        check("ab_done", done, 0);
        check("ab_grant_off", grant, 0);
        check("ab_busy", busy, 1);
        step();
        check("ab_idle", busy, 0);

        // rr_ptr=2: refresh and withdrawal together count as normal.
        req = 4'b0100;
        step();
        check("both_grant", grant, 32'h4);
        req     = '0;
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        check("both_done", done, 32'h4);
        step();

        // rr_ptr=3: bay 3 held without refresh.
        req = 4'b1000;
        step();
        check("to_grant", grant, 32'h8);
`ifdef CHARGE_ARB_TIMEOUT_EN
        cnt = 0;
        for (int i = 0; i < 50 && disp_valid; i++) begin
            cnt++;
            step();
        end
        check("to_show_cycles", cnt, 8);
        check("to_done", done, 32'h8);
        req = '0;
        step();
`else
        repeat (120) step();
        check("noto_valid", disp_valid, 1);
        check("noto_grant", grant, 32'h8);
        serve("noto", 3);
`endif
        check("to_idle", busy, 0);

        // rr_ptr=0: serve bay 1 so rr_ptr becomes 2, then grant bay 2.
        req = 4'b0010;
        step();
        serve("pre", 1);
        req = 4'b0100;
        step();
        check("ar_grant", grant, 32'h4);

        // Asynchronous reset mid-SHOW clears outputs before the next edge.
        #2 reset = 1'b1;
        #1;
        check_idle("ar");
        @(negedge clk);
        reset = 1'b0;
        req   = 4'b1001;
        step();
        check("ar_restart", grant, 32'h1);
        req = 4'b0001;
        serve("ar", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/charge_bay_arbiter.md
Name: charge_bay_arbiter

Overview:
- Round-robin arbiter for the fare-charge datapath.
- Several charging bays finish a fare computation and each presents a 4-bit charge code.
- The arbiter grants one bay at a time the shared seven-segment display path. It latches that bay's code and holds it for viewing until the user refreshes.
- Sits between the per-bay fare compute units and the single display scanner.

Parameters:
- NUM_BAYS, 4: number of requesting bays, 2..8.
- CHARGE_W, 4: width of one charge code.
- HOLD_CYCLES, 50000: display hold length in clk cycles. Used only when the timeout feature is compiled in.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_BAYS  per-bay request, level; bay holds it while its fare is final.
- charge_in  in  NUM_BAYS*CHARGE_W  per-bay charge code; bay i occupies bits [i*CHARGE_W +: CHARGE_W].
- refresh  in  1  user acknowledge, level, sampled on clk.
- grant  out  NUM_BAYS  one-hot grant; all zero when no bay is granted.
- disp_charge  out  CHARGE_W  latched charge code of the granted bay.
- disp_bay  out  $clog2(NUM_BAYS)  index of the granted bay.
- disp_valid  out  1  display path owned; disp_charge and disp_bay are valid.
- done  out  NUM_BAYS  one-cycle completion pulse to the served bay.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - state=IDLE; rr_ptr=0; hold_cnt=0.
  - grant=0, disp_charge=0, disp_bay=0, disp_valid=0, done=0, busy=0.
- States: IDLE, SHOW, DONE.
- IDLE:
  - If any req bit is set, pick the first requesting bay scanning upward from rr_ptr, wrapping modulo NUM_BAYS.
  - On that same edge, register grant (one-hot), disp_bay, disp_charge = that bay's charge_in slice, and disp_valid=1; go to SHOW.
  - Latency from req sampled high to grant high is 1 clk.
  - With no req, stay in IDLE with all outputs held at their reset values.
- SHOW:
  - disp_charge is frozen; later changes on charge_in are ignored.
  - hold_cnt increments every cycle.
  - refresh=1 → DONE with a normal completion.
  - req[disp_bay]=0 (bay withdrew) → DONE with an aborted completion.
  - Both in the same cycle → normal completion.
  - Otherwise remain in SHOW.
- DONE (exactly one cycle):
  - done[disp_bay]=1 for a normal completion only; no pulse for an abort.
  - grant=0, disp_valid=0, hold_cnt=0.
  - rr_ptr = (disp_bay+1) mod NUM_BAYS, wrapping NUM_BAYS-1 → 0.
  - Next state is IDLE.
- The served bay must drop req after done. If it keeps req high it becomes eligible again, but only after the other requesters, because rr_ptr has already advanced.
- New requests arriving during SHOW or DONE are queued implicitly as level req; nothing is lost.
- Charge codes are passed through unchecked; codes 0 and 11..15 are granted and displayed like any other.
- Width and wrap rules:
  - hold_cnt is $clog2(HOLD_CYCLES) bits wide and saturates at HOLD_CYCLES-1.
  - rr_ptr arithmetic is modulo NUM_BAYS, including non-power-of-two values.

Optional Feature:
- Macro CHARGE_ARB_TIMEOUT_EN.
- Defined: in SHOW, hold_cnt==HOLD_CYCLES-1 forces DONE as a normal completion (done pulses). A timeout coinciding with refresh or withdrawal counts as one normal completion.
- Undefined: no timeout; only refresh or withdrawal leaves SHOW. hold_cnt still counts and saturates but has no effect.

Decomposition:
- Package charge_arb_pkg:
  - state enum (IDLE, SHOW, DONE).
  - CHARGE_W default.
  - charge code constants CHG_NONE=0 .. CHG_TEN=10.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: any-valid flag, index, one-hot.
  - Instanced once.

Test Plan (NUM_BAYS=4, HOLD_CYCLES=8 for simulation):
- Reset, then req=4'b0100 with charge_in[bay2]=5 → next edge: grant=4'b0100, disp_bay=2, disp_charge=5, disp_valid=1, busy=1.
- Continuing from the first scenario, refresh=1 for 1 clk → DONE: done=4'b0100 for 1 clk, grant=0, disp_valid=0. Then IDLE with rr_ptr=3.
- req=4'b1111 held; bays ack each grant with refresh and drop req after done → grant order 0,1,2,3; the bay-3 completion wraps rr_ptr to 0.
- Granted bay 1 (charge 7) drops req in SHOW while charge_in[bay1] changes to 9 → disp_charge stays 7 throughout SHOW; DONE occurs with no done pulse.
- With CHARGE_ARB_TIMEOUT_EN: grant, no refresh → exactly 8 cycles in SHOW, then a done pulse. Without the macro: SHOW persists for 100+ cycles.
- Assert reset asynchronously mid-SHOW → all outputs 0 immediately (before the next clk edge); the FSM restarts in IDLE with rr_ptr=0.
